// File: rtl/mul_share_arbiter_if.sv
// Bundle of requester-side and multiplier-side signals for mul_share_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mul_share_arbiter_if #(
    parameter int unsigned parallelism = 32,
    parameter int unsigned NREQ        = 2
);
    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ-1:0]             req_usigned;
    logic [NREQ*parallelism-1:0] req_multiplicand;
    logic [NREQ*parallelism-1:0] req_multiplier;
    logic [NREQ-1:0]             resp_valid;
    logic [NREQ-1:0]             resp_ready;
    logic [2*parallelism-1:0]    resp_product;
    logic                        mul_valid;
    logic                        mul_usigned;
    logic [parallelism-1:0]      mul_multiplicand;
    logic [parallelism-1:0]      mul_multiplier;
    logic [2*parallelism-1:0]    mul_product;
    logic                        mul_res_ready;

    modport slave (
        input  req_valid, req_usigned, req_multiplicand, req_multiplier,
        input  resp_ready, mul_product, mul_res_ready,
        output req_ready, resp_valid, resp_product,
        output mul_valid, mul_usigned, mul_multiplicand, mul_multiplier
    );

    modport master (
        output req_valid, req_usigned, req_multiplicand, req_multiplier,
        output resp_ready, mul_product, mul_res_ready,
        input  req_ready, resp_valid, resp_product,
        input  mul_valid, mul_usigned, mul_multiplicand, mul_multiplier
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one multiplier among NREQ requesters; one job
// in flight at a time, product returned to the granted requester.
module mul_share_arbiter #(
    parameter int unsigned parallelism = 32,
    parameter int unsigned NREQ        = 2
) (
    input  logic                clk,
    input  logic                rst,
    mul_share_arbiter_if.slave  bus,
    output logic                busy
);
    localparam int unsigned IDX_W = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

    state_t                   state;
    logic [IDX_W-1:0]         last;
    logic [IDX_W-1:0]         gnt_q;
    logic [IDX_W-1:0]         gnt;
    logic [IDX_W-1:0]         cand;
    logic                     gnt_found;
    int unsigned              idx;
    logic                     res_q;
    logic                     done;
    logic [NREQ-1:0]          req_ready_c;
    logic [NREQ-1:0]          resp_valid_q;
    logic                     mul_valid_q;
    logic                     usigned_q;
    logic [parallelism-1:0]   mcand_q;
    logic [parallelism-1:0]   mplier_q;
    logic [2*parallelism-1:0] prod_q;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        gnt       = '0;
        gnt_found = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx  = (32'(last) + k) % NREQ;
            cand = IDX_W'(idx);
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt       = cand;
                gnt_found = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready_c = '0;
        if (state == IDLE && gnt_found)
            req_ready_c[gnt] = 1'b1;
    end

    // Only a fresh rising edge counts, so a level left high by the previous job is ignored.
    assign done = bus.mul_res_ready && !res_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last         <= IDX_W'(NREQ - 1);
            gnt_q        <= '0;
            res_q        <= 1'b0;
            resp_valid_q <= '0;
            mul_valid_q  <= 1'b0;
            usigned_q    <= 1'b0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            prod_q       <= '0;
        end else begin
            res_q <= bus.mul_res_ready;
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        gnt_q       <= gnt;
                        last        <= gnt;
                        usigned_q   <= bus.req_usigned[gnt];
                        mcand_q     <= bus.req_multiplicand[gnt*parallelism +: parallelism];
                        mplier_q    <= bus.req_multiplier[gnt*parallelism +: parallelism];
                        mul_valid_q <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    mul_valid_q <= 1'b0;
                    state       <= BUSY;
                end
                BUSY: begin
                    if (done) begin
                        prod_q              <= bus.mul_product;
                        resp_valid_q[gnt_q] <= 1'b1;
                        state               <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_ready[gnt_q]) begin
                        resp_valid_q <= '0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready        = req_ready_c;
    assign bus.resp_valid       = resp_valid_q;
    assign bus.resp_product     = prod_q;
    assign bus.mul_valid        = mul_valid_q;
    assign bus.mul_usigned      = usigned_q;
    assign bus.mul_multiplicand = mcand_q;
    assign bus.mul_multiplier   = mplier_q;
    assign busy                 = (state != IDLE);
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a small behavioural multiplier
// whose completion level can be held stale across job starts.
module tb_mul_share_arbiter;
    logic clk;
    logic rst;
    logic busy;

    int unsigned total = 0;
    int unsigned bad   = 0;

    mul_share_arbiter_if #(.parallelism(32), .NREQ(2)) bus ();

    mul_share_arbiter #(.parallelism(32), .NREQ(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: drops completion after stale_hold edges, raises it lat edges later.
    int unsigned stale_hold = 0;
    int unsigned lat        = 3;
    int unsigned hold_cnt;
    int unsigned lat_cnt;
    logic        m_active;
    logic [63:0] pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mul_res_ready <= 1'b0;
            bus.mul_product   <= '0;
            m_active          <= 1'b0;
            hold_cnt          <= 0;
            lat_cnt           <= 0;
            pend              <= '0;
        end else if (bus.mul_valid) begin
            if (bus.mul_usigned)
                pend <= {32'd0, bus.mul_multiplicand} * {32'd0, bus.mul_multiplier};
            else
                pend <= $signed({{32{bus.mul_multiplicand[31]}}, bus.mul_multiplicand}) *
                        $signed({{32{bus.mul_multiplier[31]}}, bus.mul_multiplier});
            hold_cnt <= stale_hold;
            lat_cnt  <= lat;
            m_active <= 1'b1;
            if (stale_hold == 0) bus.mul_res_ready <= 1'b0;
        end else if (m_active) begin
            if (hold_cnt != 0) begin
                hold_cnt <= hold_cnt - 1;
                if (hold_cnt == 1) bus.mul_res_ready <= 1'b0;
            end else if (lat_cnt > 1) begin
                lat_cnt <= lat_cnt - 1;
            end else begin
                bus.mul_product   <= pend;
                bus.mul_res_ready <= 1'b1;
                m_active          <= 1'b0;
            end
        end
    end

    int unsigned mulv_cnt = 0;
    always @(posedge clk) if (!rst && bus.mul_valid) mulv_cnt <= mulv_cnt + 1;

    task automatic present(input int idx, input logic us, input logic [31:0] a, input logic [31:0] b);
        bus.req_usigned[idx]              = us;
        bus.req_multiplicand[idx*32 +: 32] = a;
        bus.req_multiplier[idx*32 +: 32]   = b;
        bus.req_valid[idx]                = 1'b1;
    endtask

    task automatic wait_resp(output bit timed_out);
        int unsigned n;
        n = 0;
        timed_out = 1'b0;
        while (bus.resp_valid == '0) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                timed_out = 1'b1;
                break;
            end
        end
    endtask

    task automatic consume(input int idx);
        bus.resp_ready[idx] = 1'b1;
        @(negedge clk);
        bus.resp_ready[idx] = 1'b0;
    endtask

    task automatic test_reset;
        rst                  = 1'b1;
        bus.req_valid        = '0;
        bus.req_usigned      = '0;
        bus.req_multiplicand = '0;
        bus.req_multiplier   = '0;
        bus.resp_ready       = '0;
        repeat (2) @(negedge clk);
        total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b want=00", bus.req_ready); end
        total++; if (bus.resp_valid !== 2'b00) begin bad++; $display("FAIL reset_resp_valid got=%b want=00", bus.resp_valid); end
        total++; if (bus.mul_valid !== 1'b0) begin bad++; $display("FAIL reset_mul_valid got=%b want=0", bus.mul_valid); end
        total++; if (bus.mul_multiplicand !== 32'd0) begin bad++; $display("FAIL reset_mul_multiplicand got=%h want=0", bus.mul_multiplicand); end
        total++; if (bus.resp_product !== 64'd0) begin bad++; $display("FAIL reset_resp_product got=%h want=0", bus.resp_product); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b want=0", busy); end
    endtask

    task automatic test_unsigned;
        int unsigned c0;
        bit to;
        c0 = mulv_cnt;
        present(0, 1'b1, 32'd3, 32'd5);
        #1;
        total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL uns_req_ready got=%b want=01", bus.req_ready); end
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        #1;
        total++; if (bus.mul_valid !== 1'b1) begin bad++; $display("FAIL uns_issue_mul_valid got=%b want=1", bus.mul_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL uns_issue_busy got=%b want=1", busy); end
        total++; if ({bus.mul_usigned, bus.mul_multiplicand, bus.mul_multiplier} !== {1'b1, 32'd3, 32'd5}) begin
            bad++; $display("FAIL uns_operands got=%b/%h/%h want=1/3/5", bus.mul_usigned, bus.mul_multiplicand, bus.mul_multiplier);
        end
        @(negedge clk);
        total++; if (bus.mul_valid !== 1'b0) begin bad++; $display("FAIL uns_busy_mul_valid got=%b want=0", bus.mul_valid); end
        wait_resp(to);
        total++; if (to) begin bad++; $display("FAIL uns_resp_timeout got=none want=resp_valid"); end
        total++; if (bus.resp_valid !== 2'b01) begin bad++; $display("FAIL uns_resp_valid got=%b want=01", bus.resp_valid); end
        total++; if (bus.resp_product !== 64'h000000000000000F) begin bad++; $display("FAIL uns_product got=%h want=F", bus.resp_product); end
        total++; if (mulv_cnt - c0 !== 1) begin bad++; $display("FAIL uns_mul_pulses got=%0d want=1", mulv_cnt - c0); end
        consume(0);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL uns_done_busy got=%b want=0", busy); end
        total++; if (bus.resp_valid !== 2'b00) begin bad++; $display("FAIL uns_done_resp_valid got=%b want=00", bus.resp_valid); end
    endtask

    task automatic test_signed;
        bit to;
        present(1, 1'b0, 32'hFFFFFFFF, 32'h00000002);
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        wait_resp(to);
        total++; if (to) begin bad++; $display("FAIL sgn_resp_timeout got=none want=resp_valid"); end
        total++; if (bus.resp_valid !== 2'b10) begin bad++; $display("FAIL sgn_resp_valid got=%b want=10", bus.resp_valid); end
        total++; if (bus.resp_product !== 64'hFFFFFFFFFFFFFFFE) begin bad++; $display("FAIL sgn_product got=%h want=FFFFFFFFFFFFFFFE", bus.resp_product); end
        consume(1);
    endtask

    task automatic test_contention;
        bit to;
        int exp_order[6] = '{0, 1, 0, 1, 0, 1};
        logic [1:0]  exp_v;
        logic [63:0] exp_p;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        present(0, 1'b1, 32'd2, 32'd3);
        present(1, 1'b1, 32'd4, 32'd5);
        for (int j = 0; j < 6; j++) begin
            exp_v = (exp_order[j] == 0) ? 2'b01 : 2'b10;
            exp_p = (exp_order[j] == 0) ? 64'd6 : 64'd20;
            wait_resp(to);
            total++; if (to) begin bad++; $display("FAIL cont_timeout job=%0d got=none want=resp_valid", j); end
            total++; if (bus.resp_valid !== exp_v) begin bad++; $display("FAIL cont_grant job=%0d got=%b want=%b", j, bus.resp_valid, exp_v); end
            total++; if (bus.resp_product !== exp_p) begin bad++; $display("FAIL cont_product job=%0d got=%0d want=%0d", j, bus.resp_product, exp_p); end
            consume(exp_order[j]);
        end
        bus.req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        bit to;
        present(0, 1'b1, 32'd9, 32'd9);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        wait_resp(to);
        total++; if (to) begin bad++; $display("FAIL bp_timeout got=none want=resp_valid"); end
        present(1, 1'b1, 32'd1, 32'd1);
        bus.resp_ready[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++; if (bus.resp_valid !== 2'b01) begin bad++; $display("FAIL bp_resp_valid cyc=%0d got=%b want=01", c, bus.resp_valid); end
            total++; if (bus.resp_product !== 64'd81) begin bad++; $display("FAIL bp_product cyc=%0d got=%0d want=81", c, bus.resp_product); end
            total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL bp_req_ready cyc=%0d got=%b want=00", c, bus.req_ready); end
            @(negedge clk);
        end
        bus.resp_ready[1] = 1'b0;
        consume(0);
        #1;
        total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL bp_next_grant got=%b want=10", bus.req_ready); end
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        wait_resp(to);
        total++; if (bus.resp_valid !== 2'b10 || bus.resp_product !== 64'd1) begin
            bad++; $display("FAIL bp_second_job got=%b/%0d want=10/1", bus.resp_valid, bus.resp_product);
        end
        consume(1);
    endtask

    task automatic test_stale;
        bit to;
        stale_hold = 3;
        lat        = 2;
        present(0, 1'b1, 32'd11, 32'd13);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        wait_resp(to);
        total++; if (to) begin bad++; $display("FAIL stale_timeout got=none want=resp_valid"); end
        total++; if (bus.resp_valid !== 2'b01) begin bad++; $display("FAIL stale_resp_valid got=%b want=01", bus.resp_valid); end
        total++; if (bus.resp_product !== 64'd143) begin bad++; $display("FAIL stale_product got=%0d want=143", bus.resp_product); end
        consume(0);
        stale_hold = 0;
        lat        = 3;
    endtask

    task automatic test_reset_busy;
        bit to;
        bit seen;
        lat = 10;
        present(0, 1'b1, 32'd5, 32'd5);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rb_busy got=%b want=0", busy); end
        total++; if (bus.mul_valid !== 1'b0 || bus.resp_valid !== 2'b00 || bus.req_ready !== 2'b00) begin
            bad++; $display("FAIL rb_handshakes got=%b/%b/%b want=0/00/00", bus.mul_valid, bus.resp_valid, bus.req_ready);
        end
        total++; if ({bus.mul_usigned, bus.mul_multiplicand, bus.mul_multiplier} !== 65'd0) begin
            bad++; $display("FAIL rb_operands got=%b/%h/%h want=0/0/0", bus.mul_usigned, bus.mul_multiplicand, bus.mul_multiplier);
        end
        total++; if (bus.resp_product !== 64'd0) begin bad++; $display("FAIL rb_product got=%h want=0", bus.resp_product); end
        @(negedge clk);
        rst  = 1'b0;
        lat  = 3;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.resp_valid != 2'b00) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rb_ghost_resp got=1 want=0"); end
        present(0, 1'b1, 32'd7, 32'd6);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        wait_resp(to);
        total++; if (to) begin bad++; $display("FAIL rb_fresh_timeout got=none want=resp_valid"); end
        total++; if (bus.resp_valid !== 2'b01 || bus.resp_product !== 64'd42) begin
            bad++; $display("FAIL rb_fresh_job got=%b/%0d want=01/42", bus.resp_valid, bus.resp_product);
        end
        consume(0);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rb_final_busy got=%b want=0", busy); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_contention();
        test_backpressure();
        test_stale();
        test_reset_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin arbiter and sequencer that shares one `MultiplierUnit` instance between `NREQ` requesters. It accepts operand requests over per-requester valid/ready handshakes and launches each accepted request as a one-cycle `valid` pulse to the multiplier. It then waits for the multiplier's completion and returns the 2·`parallelism`-bit product to the owning requester. It sits between the core-side issue ports and the single multiplier datapath.

## Interface
- `parallelism`, 32: operand width; product width is 2·`parallelism`.
- `NREQ`, 2: number of requesters (2..8); requester i uses slice i of each flattened bus.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset. One clock domain only.
- `req_valid`  in  NREQ: request i holds valid operands.
- `req_ready`  out  NREQ: arbiter accepts request i this cycle.
- `req_usigned`  in  NREQ: 1 = unsigned multiply, 0 = signed (two's complement).
- `req_multiplicand`  in  NREQ·parallelism: multiplicand of requester i.
- `req_multiplier`  in  NREQ·parallelism: multiplier of requester i.
- `resp_valid`  out  NREQ: product for requester i is available (one-hot or zero).
- `resp_ready`  in  NREQ: requester i consumes the response.
- `resp_product`  out  2·parallelism: shared product bus, meaningful only where `resp_valid` is set.
- `mul_valid`  out  1: one-cycle start pulse to the multiplier.
- `mul_usigned`  out  1: signedness to the multiplier.
- `mul_multiplicand`  out  parallelism: operand to the multiplier.
- `mul_multiplier`  out  parallelism: operand to the multiplier.
- `mul_product`  in  2·parallelism: multiplier result.
- `mul_res_ready`  in  1: multiplier completion flag.
- `busy`  out  1: state ≠ IDLE.

## Operation
- FSM states: IDLE → ISSUE → BUSY → RESP → IDLE.
- IDLE:
  - Grant `g` = first requester with `req_valid` set, searching from `(last+1) mod NREQ`. `last` resets to NREQ−1, so requester 0 has top priority after reset.
  - `req_ready[g]` = 1, combinational from `req_valid`, and only in IDLE. All other `req_ready` bits are 0.
  - On handshake (`req_valid[g]` && `req_ready[g]`): latch the operands, `usigned` and `g` into registers, set `last` := `g`, go to ISSUE.
- ISSUE: `mul_valid` = 1 for exactly one cycle; go to BUSY.
- `mul_usigned`, `mul_multiplicand` and `mul_multiplier` are driven from the latched registers. They are stable from ISSUE until leaving RESP.
- BUSY:
  - `res_q` registers `mul_res_ready` every cycle.
  - Completion is the rising edge: `mul_res_ready` && !`res_q`.
  - On completion: capture `mul_product` into the product register, go to RESP.
  - A level-high `mul_res_ready` left over from a previous operation is not a completion.
- RESP:
  - `resp_valid[g]` = 1 and `resp_product` = captured product, both held stable until `resp_ready[g]`.
  - On that handshake go to IDLE.
  - `resp_ready` of non-granted requesters is ignored.
- At most one operation is outstanding. No new request is accepted until RESP completes.
- Arithmetic is performed entirely by the multiplier. The arbiter does no width conversion; the product passes through unmodified.

## Timing
- Reset values: `req_ready` = 0 (IDLE with no `req_valid`), `resp_valid` = 0, `mul_valid` = 0, `mul_*` operands = 0, `resp_product` = 0, `busy` = 0, `res_q` = 0, state = IDLE.
- Cycle timeline (n = accept edge):
  - Accept at edge n.
  - `mul_valid` high during cycle n+1.
  - BUSY from n+2.
  - Completion rising edge seen in cycle k (k ≥ n+2).
  - `resp_valid` high from cycle k+1.
  - Response consumed at edge m → IDLE in cycle m+1; the next accept is possible at the end of cycle m+1.
- Overhead added by the arbiter: 1 cycle (ISSUE) plus 1 cycle (RESP capture) beyond the multiplier's own latency, plus 1 IDLE cycle between back-to-back jobs.
- `rst` asserted at any point, including mid-BUSY, immediately clears every register and output. An in-flight job is discarded and produces no response. The multiplier is reset by the same system reset.
- `req_valid` dropped before the handshake has no effect. A request withdrawn while not granted is simply skipped.

## Test plan
- Single unsigned job: req0 presents `usigned`=1, multiplicand=3, multiplier=5 → `mul_valid` pulses once; `resp_valid[0]` goes high with `resp_product` = 0x000000000000000F; `busy` returns to 0 after the response handshake.
- Signed job: req1 presents `usigned`=0, multiplicand=0xFFFFFFFF, multiplier=0x00000002 → `resp_product` = 0xFFFFFFFFFFFFFFFE on `resp_valid[1]` only.
- Contention after reset: req0 and req1 both valid from the same cycle → req0 served first, req1 second. With both held continuously valid over 6 jobs, the grant order is 0,1,0,1,0,1.
- Backpressure: `resp_ready[0]` held low 5 cycles in RESP → `resp_valid[0]` and `resp_product` are stable for those cycles, and `req_ready` stays all-0 even with req1 valid.
- Stale completion: `mul_res_ready` still high when BUSY is entered → no capture until it falls and rises again. The product returned is from the new rising edge.
- Reset mid-BUSY: `rst` pulsed 2 cycles after `mul_valid` → all outputs 0 and state IDLE at once. No `resp_valid` appears for the aborted job. A fresh req0 job (7×6) afterwards returns 42.
